alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning the number of 8-bit general registers; legal value is 8 only, giving 3-bit register addresses.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a rising edge.
REQ-006 SHALL have port cmd_op  in  3  ALU operation code, passed through unmodified.
REQ-007 SHALL have ports cmd_ra, cmd_rb, cmd_rd  in  3 each  source A, source B and destination register indices.
REQ-008 SHALL have port cmd_cin  in  1  carry-in for the command (see REQ-026).
REQ-009 SHALL have ports alu_a, alu_b  out  8 each, alu_op  out  3, alu_cin  out  1  operands to the downstream ALU.
REQ-010 SHALL have ports alu_y  in  8, alu_cout, alu_ovf, alu_zero, alu_neg  in  1 each  registered ALU results, valid one cycle after operands are presented.
REQ-011 SHALL have port flags  out  4  {C,V,Z,N} from the last completed command.
REQ-012 SHALL have port done  out  1  one-cycle pulse per completed command.
REQ-013 SHALL have ports dbg_addr  in  3 and dbg_data  out  8  combinational register read-back.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ISSUE, WB.
REQ-015 SHALL assert cmd_ready only in IDLE.
- IDLE with cmd_valid = 1 -> ISSUE.
- ISSUE -> WB unconditionally.
- WB -> IDLE unconditionally.
REQ-016 SHALL, on acceptance, register the following, all stable through ISSUE and WB:
- alu_a = R[cmd_ra]
- alu_b = R[cmd_rb]
- alu_op = cmd_op
- alu_cin
- rd
REQ-017 SHALL leave the ALU to sample its operands at the edge ending ISSUE, and SHALL capture alu_y and the ALU flags at the edge ending WB.
REQ-018 SHALL, at the edge ending WB, write:
- R[rd] = alu_y
- flags = {alu_cout, alu_ovf, alu_zero, alu_neg}
REQ-019 SHALL assert done, registered, for exactly the one cycle following the WB edge.
- Latency: acceptance edge to done high = 3 cycles.
- Throughput: at most one command per 3 cycles.
REQ-020 SHALL read source operands at acceptance, so ra or rb equal to rd uses the pre-write value.
REQ-021 SHALL make a command accepted in the cycle done is high (back-to-back) observe the just-written register value.
REQ-022 SHALL write R[rd] for every cmd_op value, including 000; no register is hard-wired to zero.
REQ-023 SHALL ignore cmd_valid while in ISSUE or WB, and SHALL NOT accept or queue any command in those states.
REQ-024 SHALL make dbg_data = R[dbg_addr] combinationally, showing the post-write value from the cycle after the WB edge.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force the following, aborting any in-flight command without writeback:
- state = IDLE
- all R[i] = 0
- flags = 0
- done = 0
- alu_a, alu_b, alu_op, alu_cin = 0
- cmd_ready = 1 after release

Configuration
REQ-026 SHALL support macro ALU_SEQ_CARRY_CHAIN_EN.
- Defined: alu_cin is captured from flags[3] (C) at acceptance and cmd_cin is ignored, enabling multi-byte add chains.
- Undefined: alu_cin is captured from cmd_cin.

Verification
REQ-027 SHALL cover reset: rst_n low mid-ISSUE -> done never pulses, all R = 0, flags = 0, cmd_ready = 1 after release.
REQ-028 SHALL cover a basic write: with R1 = 0x3C, R2 = 0x0F (loaded via op 000 from preset regs), cmd op 001, ra = 1, rb = 2, rd = 3 -> alu_a = 0x3C, alu_b = 0x0F, alu_op = 001 in ISSUE; done 3 cycles after accept; dbg_addr = 3 reads the model ALU result.
REQ-029 SHALL cover busy rejection: cmd_valid held high continuously -> acceptances exactly every 3 cycles; cmd_ready low in ISSUE and WB.
REQ-030 SHALL cover a hazard: cmd rd = 2, ra = 2, followed back-to-back by cmd ra = 2 -> the first uses the old R2, the second uses the new R2.
REQ-031 SHALL cover the carry chain (macro defined): first command yields alu_cout = 1; next command drives alu_cin = 1 despite cmd_cin = 0. With the macro undefined, the same sequence gives alu_cin = 0.
REQ-032 SHALL cover flag capture: ALU model returns cout = 1, ovf = 0, zero = 1, neg = 0 -> flags = 4'b1010 from the done cycle onward, unchanged until the next WB.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer for an external registered ALU: 8x8 register file, IDLE/ISSUE/WB FSM.
// Define ALU_SEQ_CARRY_CHAIN_EN to feed the stored carry flag back as carry-in.
module alu_seq #(
    parameter int NREG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_ra,
    input  logic [2:0] cmd_rb,
    input  logic [2:0] cmd_rd,
    input  logic       cmd_cin,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_cin,
    input  logic [7:0] alu_y,
    input  logic       alu_cout,
    input  logic       alu_ovf,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic [3:0] flags,
    output logic       done,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    state_t     state;
    logic [7:0] regs [NREG];
    logic [2:0] rd_q;
    logic       cin_sel;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    logic unused_cmd_cin;
    assign unused_cmd_cin = cmd_cin;
    assign cin_sel        = flags[3];
`else
    assign cin_sel = cmd_cin;
`endif

    assign cmd_ready = (state == IDLE);
    assign dbg_data  = regs[dbg_addr];

    // Operands are latched at acceptance so a same-register destination sees the old value;
    // the ALU result arrives one cycle later and is written back at the edge ending WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
            flags   <= 4'b0000;
            done    <= 1'b0;
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_op  <= 3'b000;
            alu_cin <= 1'b0;
            rd_q    <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= ISSUE;
                        alu_a   <= regs[cmd_ra];
                        alu_b   <= regs[cmd_rb];
                        alu_op  <= cmd_op;
                        alu_cin <= cin_sel;
                        rd_q    <= cmd_rd;
                    end
                end
                ISSUE: begin
                    state <= WB;
                end
                WB: begin
                    regs[rd_q] <= alu_y;
                    flags      <= {alu_cout, alu_ovf, alu_zero, alu_neg};
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a small registered ALU model attached.
// Expected results are hand-computed constants; ALU_SEQ_CARRY_CHAIN_EN changes the carry test expectation.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_ra;
    logic [2:0] cmd_rb;
    logic [2:0] cmd_rd;
    logic       cmd_cin;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_cin;
    logic [7:0] alu_y;
    logic       alu_cout;
    logic       alu_ovf;
    logic       alu_zero;
    logic       alu_neg;
    logic [3:0] flags;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    logic [7:0] load_val;
    logic [3:0] exp_flags;
    int         tests_run;
    int         tests_failed;

    alu_seq #(.NREG(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_ra   (cmd_ra),
        .cmd_rb   (cmd_rb),
        .cmd_rd   (cmd_rd),
        .cmd_cin  (cmd_cin),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_cin  (alu_cin),
        .alu_y    (alu_y),
        .alu_cout (alu_cout),
        .alu_ovf  (alu_ovf),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .flags    (flags),
        .done     (done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Op 000 loads the bench-supplied load_val, 001 adds with carry, anything else XORs.
    function automatic logic [9:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [8:0] sum;
        logic [7:0] y;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: y = load_val;
            3'b001: begin
                sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                y   = sum[7:0];
                c   = sum[8];
                v   = (a[7] == b[7]) && (y[7] != a[7]);
            end
            default: y = a ^ b;
        endcase
        return {c, v, y};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [9:0] r;
        if (!rst_n) begin
            alu_y    <= 8'h00;
            alu_cout <= 1'b0;
            alu_ovf  <= 1'b0;
            alu_zero <= 1'b0;
            alu_neg  <= 1'b0;
        end else begin
            r = alu_model(alu_op, alu_a, alu_b, alu_cin);
            alu_y    <= r[7:0];
            alu_cout <= r[9];
            alu_ovf  <= r[8];
            alu_zero <= (r[7:0] == 8'h00);
            alu_neg  <= r[7];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        checkOutput(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    // Offers a command from a negedge and returns at the negedge of the ISSUE cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                 input logic [2:0] rd, input logic cin, input logic [7:0] lv);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_cin   = cin;
        load_val  = lv;
        while (!cmd_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Runs one command and ends at the negedge of the cycle where done must be high.
    task automatic runCmd(input string tag, input logic [2:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] rd, input logic cin,
                          input logic [7:0] lv, input logic [7:0] exp_a, input logic [7:0] exp_b,
                          input logic exp_cin, input logic [3:0] exp_flags_after);
        applyStimulus(op, ra, rb, rd, cin, lv);
        checkOutput({tag, "_alu_a"}, {24'h0, alu_a}, {24'h0, exp_a});
        checkOutput({tag, "_alu_b"}, {24'h0, alu_b}, {24'h0, exp_b});
        checkOutput({tag, "_alu_op"}, {29'h0, alu_op}, {29'h0, op});
        checkOutput({tag, "_alu_cin"}, {31'h0, alu_cin}, {31'h0, exp_cin});
        checkOutput({tag, "_ready_issue"}, {31'h0, cmd_ready}, 32'd0);
        checkOutput({tag, "_done_c1"}, {31'h0, done}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_ready_wb"}, {31'h0, cmd_ready}, 32'd0);
        checkOutput({tag, "_done_c2"}, {31'h0, done}, 32'd0);
        checkOutput({tag, "_flags_hold"}, {28'h0, flags}, {28'h0, exp_flags});
        checkOutput({tag, "_alu_a_stable"}, {24'h0, alu_a}, {24'h0, exp_a});
        @(negedge clk);
        checkOutput({tag, "_done_c3"}, {31'h0, done}, 32'd1);
        checkOutput({tag, "_flags"}, {28'h0, flags}, {28'h0, exp_flags_after});
        checkOutput({tag, "_ready_idle"}, {31'h0, cmd_ready}, 32'd1);
        exp_flags = exp_flags_after;
    endtask

    initial begin
        logic exp_chain_cin;
        logic [7:0] exp_chain_y;
        tests_run    = 0;
        tests_failed = 0;
        exp_flags    = 4'b0000;
        load_val     = 8'h00;
        cmd_valid    = 1'b0;
        cmd_op       = 3'b000;
        cmd_ra       = 3'b000;
        cmd_rb       = 3'b000;
        cmd_rd       = 3'b000;
        cmd_cin      = 1'b0;
        dbg_addr     = 3'b000;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_done", {31'h0, done}, 32'd0);
        checkOutput("rst_flags", {28'h0, flags}, 32'd0);
        checkOutput("rst_alu_a", {24'h0, alu_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, cmd_ready}, 32'd1);
        checkReg("rst_r3", 3'd3, 8'h00);

        // Preload R1/R2 through the model's load op, then a basic add into R3.
        runCmd("load_r1", 3'b000, 3'd0, 3'd0, 3'd1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, 4'b0000);
        runCmd("load_r2", 3'b000, 3'd0, 3'd0, 3'd2, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0, 4'b0000);
        checkReg("r1", 3'd1, 8'h3C);
        checkReg("r2", 3'd2, 8'h0F);
        runCmd("add", 3'b001, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 8'h3C, 8'h0F, 1'b0, 4'b0000);
        checkReg("r3", 3'd3, 8'h4B);

        // Hazard: R2 <= R2+R2, then back-to-back use of the new R2.
        runCmd("haz1", 3'b001, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00, 8'h0F, 8'h0F, 1'b0, 4'b0000);
        runCmd("haz2", 3'b001, 3'd2, 3'd1, 3'd4, 1'b0, 8'h00, 8'h1E, 8'h3C, 1'b0, 4'b0000);
        checkReg("r2_new", 3'd2, 8'h1E);
        checkReg("r4", 3'd4, 8'h5A);

        // 0xFF + 0x01 gives C=1, V=0, Z=1, N=0.
        runCmd("load_r5", 3'b000, 3'd0, 3'd0, 3'd5, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 4'b0001);
        runCmd("load_r6", 3'b000, 3'd0, 3'd0, 3'd6, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 4'b0000);
        runCmd("flag", 3'b001, 3'd5, 3'd6, 3'd7, 1'b0, 8'h00, 8'hFF, 8'h01, 1'b0, 4'b1010);
        checkReg("r7", 3'd7, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("flags_idle_hold", {28'h0, flags}, 32'hA);

`ifdef ALU_SEQ_CARRY_CHAIN_EN
        exp_chain_cin = 1'b1;
        exp_chain_y   = 8'h4C;
`else
        exp_chain_cin = 1'b0;
        exp_chain_y   = 8'h4B;
`endif
        runCmd("chain", 3'b001, 3'd1, 3'd2, 3'd0, 1'b0, 8'h00, 8'h3C, 8'h1E, exp_chain_cin, 4'b0000);
        checkReg("r0_chain", 3'd0, exp_chain_y + 8'h0F);

        // Continuous cmd_valid: ready (and acceptance) exactly every third cycle.
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd1;
        cmd_rd    = 3'd6;
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("busy_ready_%0d", i), {31'h0, cmd_ready}, {31'h0, (i % 3) == 0});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkOutput("busy_done", {31'h0, done}, 32'd1);
        checkOutput("busy_flags", {28'h0, flags}, 32'h2);
        checkReg("busy_r6", 3'd6, 8'h00);
        @(negedge clk);

        // Reset in the middle of ISSUE aborts the load into R1.
        applyStimulus(3'b000, 3'd0, 3'd0, 3'd1, 1'b1, 8'h77);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_flags", {28'h0, flags}, 32'd0);
        checkOutput("abort_alu_a", {24'h0, alu_a}, 32'd0);
        checkOutput("abort_alu_b", {24'h0, alu_b}, 32'd0);
        checkOutput("abort_alu_op", {29'h0, alu_op}, 32'd0);
        checkOutput("abort_alu_cin", {31'h0, alu_cin}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_done_rst_%0d", i), {31'h0, done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_done_%0d", i), {31'h0, done}, 32'd0);
            checkOutput($sformatf("abort_ready_%0d", i), {31'h0, cmd_ready}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            checkReg($sformatf("abort_r%0d", i), 3'(i), 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
